// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and slice helpers
// for the systolic array operand sequencer.
package systolic_pkg;

   localparam int SYS_N     = 4;
   localparam int SYS_DW    = 8;
   localparam int SYS_DRAIN = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_e;

   function automatic int lane_lo(input int lane, input int dw);
      return lane * dw;
   endfunction

   // Step counter must hold the longest of the FEED and DRAIN phases.
   function automatic int cnt_width(input int n, input int drain);
      int m;
      m = (2 * n - 1 > drain) ? 2 * n - 1 : drain;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/systolic_skew.sv
// Builds one diagonally skewed word: lane i carries
// lane i of buffer word (step - i) while feeding.
module systolic_skew
   import systolic_pkg::*;
#(
   parameter int N  = SYS_N,
   parameter int DW = SYS_DW,
   parameter int CW = 3
) (
   input  logic [N*DW-1:0] buf_i [N],
   input  logic [CW-1:0]   step_i,
   input  logic            feed_i,
   output logic [N*DW-1:0] word_o
);

   always_comb begin
      word_o = '0;
      if (feed_i) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (step_i == CW'(i + k)) begin
                  word_o[lane_lo(i, DW) +: DW] =
                     buf_i[k][lane_lo(i, DW) +: DW];
               end
            end
         end
      end
   end

endmodule

// File: rtl/systolic_sequencer.sv
// Operand sequencer: buffers data/weight words and streams
// them skewed into a systolic array, one job per start.
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int N     = SYS_N,
   parameter int DW    = SYS_DW,
   parameter int DRAIN = SYS_DRAIN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [$clog2(N)-1:0] wr_addr,
   input  logic [N*DW-1:0]      wr_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 array_reset,
   output logic [N*DW-1:0]      datain,
   output logic [N*DW-1:0]      weightin
);

   localparam int CW = cnt_width(N, DRAIN);
   localparam int WW = N * DW;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]   d_buf_q [N];
   logic [WW-1:0]   d_buf_d [N];
   logic [WW-1:0]   w_buf_q [N];
   logic [WW-1:0]   w_buf_d [N];
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            clr_q, clr_d;
   logic [WW-1:0]   din_q, din_d;
   logic [WW-1:0]   win_q, win_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_buf_d = d_buf_q;
      w_buf_d = w_buf_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (wr_en) begin
               if (wr_sel) w_buf_d[wr_addr] = wr_data;
               else        d_buf_d[wr_addr] = wr_data;
            end
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_FEED;
         end
         S_FEED: begin
            if (cnt_q == CW'(2 * N - 2)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(DRAIN - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode the next state so they line up with state_q.
   always_comb begin
      busy_d = (state_d == S_CLEAR) || (state_d == S_FEED)
            || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      clr_d  = (state_d == S_CLEAR);
   end

   systolic_skew #(.N(N), .DW(DW), .CW(CW)) u_skew_d (
      .buf_i  (d_buf_q),
      .step_i (cnt_d),
      .feed_i (state_d == S_FEED),
      .word_o (din_d)
   );

   systolic_skew #(.N(N), .DW(DW), .CW(CW)) u_skew_w (
      .buf_i  (w_buf_q),
      .step_i (cnt_d),
      .feed_i (state_d == S_FEED),
      .word_o (win_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         d_buf_q <= '{default: '0};
         w_buf_q <= '{default: '0};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         din_q   <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_buf_q <= d_buf_d;
         w_buf_q <= w_buf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         din_q   <= din_d;
         win_q   <= win_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign array_reset = clr_q;
   assign datain      = din_q;
   assign weightin    = win_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: stimulus pushes
// per-cycle job expectations, a monitor pops and compares.
module tb_systolic_sequencer;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DRAIN = 7;
   localparam int WW    = N * DW;
   localparam int JOB   = 2 * N + DRAIN + 1;

   typedef struct packed {
      logic          ar;
      logic          busy;
      logic          done;
      logic [WW-1:0] din;
      logic [WW-1:0] win;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [1:0]    wr_addr = '0;
   logic [WW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          busy, done, array_reset;
   logic [WW-1:0] datain, weightin;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [WW-1:0] dm [N];
   logic [WW-1:0] wm [N];
   logic [WW-1:0] load [N] = '{32'h04030201, 32'h08070605,
                               32'h0C0B0A09, 32'h100F0E0D};
   logic [WW-1:0] tab [7]  = '{32'h00000001, 32'h00000205,
                               32'h00030609, 32'h04070A0D,
                               32'h080B0E00, 32'h0C0F0000,
                               32'h10000000};
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;

   systolic_sequencer #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .array_reset (array_reset),
      .datain      (datain),
      .weightin    (weightin)
   );

   task automatic chk(input string nm, input logic [WW-1:0] got,
                      input logic [WW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, got, exp, $time);
      end
   endtask

   // Reference: lane i at step t is lane i of word t-i, if it exists.
   function automatic logic [WW-1:0] skew_of(input logic [WW-1:0] b [N],
                                             input int t);
      logic [WW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N)
            r[i*DW +: DW] = b[t-i][i*DW +: DW];
      return r;
   endfunction

   task automatic push_job(input bit use_tab);
      exp_t e;
      for (int c = 0; c < JOB; c++) begin
         e = '0;
         if (c == 0) begin
            e.ar   = 1'b1;
            e.busy = 1'b1;
         end else if (c <= 2 * N - 1) begin
            e.busy = 1'b1;
            e.din  = use_tab ? tab[c-1] : skew_of(dm, c - 1);
            e.win  = use_tab ? tab[c-1] : skew_of(wm, c - 1);
         end else if (c < JOB - 1) begin
            e.busy = 1'b1;
         end else begin
            e.done = 1'b1;
         end
         sb.push_back(e);
      end
   endtask

   task automatic write_word(input bit sel, input int a,
                             input logic [WW-1:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = 2'(a);
      wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (sel) wm[a] = d;
      else     dm[a] = d;
   endtask

   // Called while the DUT is idle; returns just after the accepting edge.
   task automatic issue(input bit w, input bit sel, input int a,
                        input logic [WW-1:0] d, input bit use_tab);
      start   = 1'b1;
      wr_en   = w;
      wr_sel  = sel;
      wr_addr = 2'(a);
      wr_data = d;
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (w) begin
         if (sel) wm[a] = d;
         else     dm[a] = d;
      end
      push_job(use_tab);
   endtask

   // Runs out the job; disturbances land in non-idle states only.
   task automatic wait_job(input bit disturb);
      for (int j = 0; j < JOB; j++) begin
         if (disturb) begin
            start   = 1'($urandom_range(0, 1));
            wr_en   = 1'($urandom_range(0, 1));
            wr_sel  = 1'($urandom_range(0, 1));
            wr_addr = 2'($urandom_range(0, N - 1));
            wr_data = $urandom;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy === 1'b1 || done === 1'b1 || array_reset === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: busy=%b done=%b ar=%b expected idle at %0t",
                        busy, done, array_reset, $time);
            end else begin
               mon_e = sb.pop_front();
               chk("array_reset", WW'(array_reset), WW'(mon_e.ar));
               chk("busy", WW'(busy), WW'(mon_e.busy));
               chk("done", WW'(done), WW'(mon_e.done));
               chk("datain", datain, mon_e.din);
               chk("weightin", weightin, mon_e.win);
            end
         end else begin
            chk("idle_datain", datain, '0);
            chk("idle_weightin", weightin, '0);
            chk("idle_flags", {busy, done, array_reset}, '0);
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish in budget");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         dm[i] = '0;
         wm[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < N; k++) write_word(1'b1, k, load[k]);
      for (int k = 0; k < N; k++) write_word(1'b0, k, load[k]);
      issue(1'b0, 1'b0, 0, '0, 1'b1);
      wait_job(1'b1);
      issue(1'b0, 1'b0, 0, '0, 1'b1);
      wait_job(1'b0);

      issue(1'b0, 1'b0, 0, '0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      for (int i = 0; i < N; i++) begin
         dm[i] = '0;
         wm[i] = '0;
      end
      @(posedge clk); #1;
      issue(1'b0, 1'b0, 0, '0, 1'b0);
      wait_job(1'b0);

      issue(1'b1, 1'b0, 0, 32'hFFFFFFFF, 1'b0);
      wait_job(1'b0);

      for (int j = 0; j < 30; j++) begin
         repeat ($urandom_range(0, 4))
            write_word(1'($urandom_range(0, 1)),
                       $urandom_range(0, N - 1), $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, N - 1), $urandom, 1'b0);
         wait_job(1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", WW'(sb.size()), '0);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
